// File: rtl/bcd_scan_display_if.sv
// Display bus for bcd_scan_display: BCD frame input, load strobe and scanned segment/anode outputs.
interface bcd_scan_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0]       bcd_in;
  logic                          load;
  logic [6:0]                    seg;
  logic [NUM_DIGITS-1:0]         an;
  logic [$clog2(NUM_DIGITS)-1:0] digit_idx;
  logic                          frame_done;

  modport master (output bcd_in, load, input seg, an, digit_idx, frame_done);
  modport slave  (input bcd_in, load, output seg, an, digit_idx, frame_done);
endinterface

// File: rtl/bcd_scan_display.sv
// Time-multiplexed BCD 7-segment scanner with tear-free frame buffer and anti-ghost blanking.
// Optional: define LEADING_ZERO_BLANK_EN to suppress leading zeros (digit 0 always shown).
module bcd_seg_lane (
  input  logic [3:0] i_code,
  input  logic       i_blank,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = '0;
    if (!i_blank) begin
      case (i_code)
        4'd0: o_seg = 7'b1111110;
        4'd1: o_seg = 7'b0110000;
        4'd2: o_seg = 7'b1101101;
        4'd3: o_seg = 7'b1111001;
        4'd4: o_seg = 7'b0110011;
        4'd5: o_seg = 7'b1011011;
        4'd6: o_seg = 7'b1011111;
        4'd7: o_seg = 7'b1110000;
        4'd8: o_seg = 7'b1111111;
        4'd9: o_seg = 7'b1111011;
        default: o_seg = '0;
      endcase
    end
  end
endmodule

module bcd_scan_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_DIV     = 50000,
  parameter int BLANK_CYC   = 16,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input logic clk,
  input logic rst,
  bcd_scan_display_if.slave disp
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0]                 r_cnt;
  logic [IW-1:0]                 r_idx;
  logic [4*NUM_DIGITS-1:0]       r_pend;
  logic [4*NUM_DIGITS-1:0]       r_disp;
  logic [6:0]                    r_seg;
  logic [NUM_DIGITS-1:0]         r_an;

  logic                          w_slot_end;
  logic                          w_wrap;
  logic [NUM_DIGITS-1:0]         w_blank;
  logic [NUM_DIGITS-1:0][6:0]    w_lane_seg;
  logic [NUM_DIGITS-1:0]         w_an_sel;

  assign w_slot_end = (r_cnt == CW'(CLK_DIV - 1));
  assign w_wrap     = w_slot_end && (r_idx == IW'(NUM_DIGITS - 1));

  genvar k;
  generate
    for (k = 0; k < NUM_DIGITS; k++) begin : g_lane
`ifdef LEADING_ZERO_BLANK_EN
      // A digit is a leading zero when it and everything to its left is zero.
      if (k == 0) begin : g_lsd
        assign w_blank[k] = 1'b0;
      end else begin : g_upper
        assign w_blank[k] = (r_disp[4*NUM_DIGITS-1:4*k] == '0);
      end
`else
      assign w_blank[k] = 1'b0;
`endif
      bcd_seg_lane u_lane (
        .i_code (r_disp[4*k +: 4]),
        .i_blank(w_blank[k]),
        .o_seg  (w_lane_seg[k])
      );
    end
  endgenerate

  // Anodes stay off for the first BLANK_CYC cycles of a slot to hide segment transitions.
  assign w_an_sel = (r_cnt >= CW'(BLANK_CYC)) ? (NUM_DIGITS'(1) << r_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_pend <= '0;
      r_disp <= '0;
      r_seg  <= SEG_ACT_LOW ? '1 : '0;
      r_an   <= AN_ACT_LOW  ? '1 : '0;
    end else begin
      r_cnt <= w_slot_end ? '0 : r_cnt + CW'(1);
      if (w_slot_end)
        r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
      if (disp.load)
        r_pend <= disp.bcd_in;
      if (w_wrap)
        r_disp <= disp.load ? disp.bcd_in : r_pend;
      r_seg <= SEG_ACT_LOW ? ~w_lane_seg[r_idx] : w_lane_seg[r_idx];
      r_an  <= AN_ACT_LOW  ? ~w_an_sel         : w_an_sel;
    end
  end

  assign disp.seg        = r_seg;
  assign disp.an         = r_an;
  assign disp.digit_idx  = r_idx;
  assign disp.frame_done = w_wrap;
endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized check of bcd_scan_display against a slot/frame-level reference model.
module tb_bcd_scan_display;
  localparam int N       = 4;
  localparam int CLK_DIV = 4;
  localparam int BLANK   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_scan_display_if #(.NUM_DIGITS(N)) bus ();

  bcd_scan_display #(
    .NUM_DIGITS(N), .CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK),
    .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .disp(bus)
  );

  logic [6:0] SEG_TBL [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  int n_cmp = 0;
  int n_err = 0;
  int fd_seen = 0;

  // model: time since reset, pending/display frames, expected registered outputs
  int          m_t = 0;
  bit          m_valid = 1'b0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_disp = '0;
  logic [6:0]  exp_seg = '0;
  logic [3:0]  exp_an = 4'hF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d: got %0h expected %0h", tag, m_t, obs, exp);
    end
  endtask

  task automatic step(input logic ld, input logic [15:0] bcd, input logic rs);
    int   cnt, idx, code;
    bit   wrap, blank;
    cnt  = m_t % CLK_DIV;
    idx  = (m_t / CLK_DIV) % N;
    wrap = (cnt == CLK_DIV - 1) && (idx == N - 1);
    if (m_valid) begin
      chk("digit_idx",  32'(bus.digit_idx),  32'(idx));
      chk("frame_done", 32'(bus.frame_done), 32'(wrap));
      chk("seg",        32'(bus.seg),        32'(exp_seg));
      chk("an",         32'(bus.an),         32'(exp_an));
      if (bus.frame_done) fd_seen++;
    end
    bus.load   = ld;
    bus.bcd_in = bcd;
    rst        = rs;
    @(posedge clk);
    if (rs) begin
      m_t = 0; m_pend = '0; m_disp = '0; exp_seg = '0; exp_an = 4'hF;
    end else begin
      code  = int'((m_disp >> (4*idx)) & 16'hF);
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank = (idx > 0) && ((m_disp >> (4*idx)) == 16'h0);
`endif
      exp_seg = blank ? 7'h00 : SEG_TBL[code];
      exp_an  = (cnt >= BLANK) ? ~(4'b0001 << idx) : 4'hF;
      if (wrap) m_disp = ld ? bcd : m_pend;
      if (ld)   m_pend = bcd;
      m_t++;
    end
    m_valid = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0);
  endtask

  task automatic run_to(input int phase);
    for (int i = 0; i < 4*N*CLK_DIV && (m_t % (N*CLK_DIV)) != phase; i++)
      step(1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    bus.load = 1'b0;
    bus.bcd_in = '0;
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1);

    step(1'b1, 16'h1234, 1'b0);
    idle(40);
    fd_seen = 0;
    idle(64);
    chk("fd_per_64", 32'(fd_seen), 32'd4);

    run_to(5);
    step(1'b1, 16'h5678, 1'b0);
    idle(24);

    run_to(15);
    step(1'b1, 16'h9ABC, 1'b0);
    idle(20);

`ifdef LEADING_ZERO_BLANK_EN
    step(1'b1, 16'h0070, 1'b0);
    idle(36);
    step(1'b1, 16'h0000, 1'b0);
    idle(36);
`endif
    step(1'b1, 16'h0407, 1'b0);
    idle(34);

    run_to(9);
    step(1'b1, 16'hFFFF, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    idle(40);

    for (int i = 0; i < 800; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if ($urandom_range(1, 0) == 1) v = v & 16'h0F0F;
      step($urandom_range(7, 0) == 0, v, $urandom_range(199, 0) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
